// File: rtl/xoodyak_aead.sv
// Single-block Xoodyak keyed-mode AEAD engine.
// One Xoodoo round per clock; four 12-round permutations per operation:
// key/nonce absorb, AD absorb, crypt, squeeze. Result latency is 49 cycles.
module xoodyak_aead (
  input  logic         eph1,
  input  logic         reset,
  input  logic         start,
  input  logic [191:0] textin,
  input  logic [127:0] nonce,
  input  logic [127:0] assodata,
  input  logic [127:0] key,
  input  logic [127:0] verification_data,
  input  logic         opmode,
  output logic [127:0] authdata,
  output logic [191:0] textout,
  output logic         encdone,
  output logic         sqzdone,
  output logic         verify
);

  typedef enum logic [0:0] {StIdle, StPerm} fsm_e;

  fsm_e         fsm_q;
  logic [1:0]   k_q;
  logic [3:0]   rnd_q;
  logic [383:0] st_q;
  logic         opmode_q;
  logic [191:0] textin_q;
  logic [127:0] nonce_q;
  logic [127:0] ad_q;
  logic [127:0] vdata_q;

  logic [383:0] rnd_out;
  logic [383:0] inj;
  logic [383:0] init_st;
  logic [191:0] text_new;
  logic [127:0] tag;
  logic         last_rnd;

  // Ports are MSB-byte-first; the state holds byte i at st[8*i +: 8].
  function automatic logic [127:0] bswap128(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [191:0] bswap192(input logic [191:0] v);
    logic [191:0] r;
    for (int i = 0; i < 24; i++) r[8*i +: 8] = v[191-8*i -: 8];
    return r;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] round_const(input logic [3:0] r);
    case (r)
      4'd0:    return 32'h058;
      4'd1:    return 32'h038;
      4'd2:    return 32'h3C0;
      4'd3:    return 32'h0D0;
      4'd4:    return 32'h120;
      4'd5:    return 32'h014;
      4'd6:    return 32'h060;
      4'd7:    return 32'h02C;
      4'd8:    return 32'h380;
      4'd9:    return 32'h0F0;
      4'd10:   return 32'h1A0;
      4'd11:   return 32'h012;
      default: return 32'h000;
    endcase
  endfunction

  // One Xoodoo round; lane (x,y) lives at bits 32*(4y+x).
  function automatic logic [383:0] xoodoo_round(input logic [383:0] s, input logic [31:0] rc);
    logic [31:0]  a [3][4];
    logic [31:0]  b [3][4];
    logic [31:0]  p [4];
    logic [31:0]  e [4];
    logic [383:0] r;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = s[32*(4*y+x) +: 32];
    // theta
    for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
    for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ e[x];
    // rho-west
    for (int x = 0; x < 4; x++) begin
      b[0][x] = a[0][x];
      b[1][x] = a[1][(x+3)%4];
      b[2][x] = rotl(a[2][x], 11);
    end
    // iota
    b[0][0] = b[0][0] ^ rc;
    // chi
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
    // rho-east
    for (int x = 0; x < 4; x++) begin
      b[0][x] = a[0][x];
      b[1][x] = rotl(a[1][x], 1);
      b[2][x] = rotl(a[2][(x+2)%4], 8);
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) r[32*(4*y+x) +: 32] = b[y][x];
    return r;
  endfunction

  // Round datapath plus the Down/Up injection applied after each permutation.
  always_comb begin
    rnd_out  = xoodoo_round(st_q, round_const(rnd_q));
    last_rnd = (rnd_q == 4'd11);
    text_new = textin_q ^ bswap192(rnd_out[191:0]);
    tag      = bswap128(rnd_out[127:0]);

    init_st            = '0;
    init_st[127:0]     = bswap128(key);
    init_st[143:136]   = 8'h01;
    init_st[383:376]   = 8'h02;

    inj = '0;
    unique case (k_q)
      2'd0: begin
        inj[127:0]   = bswap128(nonce_q);
        inj[135:128] = 8'h01;
        inj[383:376] = 8'h03;
      end
      2'd1: begin
        inj[127:0]   = bswap128(ad_q);
        inj[135:128] = 8'h01;
        inj[383:376] = 8'h83;
      end
      2'd2: begin
        // Absorb the plaintext: the input when encrypting, the recovered text when decrypting.
        inj[191:0]   = bswap192(opmode_q ? text_new : textin_q);
        inj[199:192] = 8'h01;
        inj[383:376] = 8'h40;
      end
      default: inj = '0;
    endcase
  end

  // Control FSM, permutation state and registered outputs.
  always_ff @(posedge eph1) begin
    if (reset) begin
      fsm_q    <= StIdle;
      k_q      <= '0;
      rnd_q    <= '0;
      st_q     <= '0;
      opmode_q <= 1'b0;
      textin_q <= '0;
      nonce_q  <= '0;
      ad_q     <= '0;
      vdata_q  <= '0;
      authdata <= '0;
      textout  <= '0;
      encdone  <= 1'b0;
      sqzdone  <= 1'b0;
      verify   <= 1'b0;
    end else begin
      encdone <= 1'b0;
      sqzdone <= 1'b0;
      case (fsm_q)
        StIdle: begin
          if (start) begin
            st_q     <= init_st;
            opmode_q <= opmode;
            textin_q <= textin;
            nonce_q  <= nonce;
            ad_q     <= assodata;
            vdata_q  <= verification_data;
            k_q      <= '0;
            rnd_q    <= '0;
            fsm_q    <= StPerm;
          end
        end
        StPerm: begin
          if (last_rnd) begin
            st_q  <= rnd_out ^ inj;
            rnd_q <= '0;
            k_q   <= k_q + 2'd1;
            if (k_q == 2'd2) begin
              textout <= text_new;
              encdone <= 1'b1;
            end
            if (k_q == 2'd3) begin
              authdata <= tag;
              verify   <= opmode_q & (tag == vdata_q);
              sqzdone  <= 1'b1;
              fsm_q    <= StIdle;
            end
          end else begin
            st_q  <= rnd_out;
            rnd_q <= rnd_q + 4'd1;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_xoodyak_aead.sv
// Self-checking bench for xoodyak_aead: table of vectors with expectations from a
// byte-level Cyclist/Xoodoo model, plus chained decrypt, busy-start and reset sequences.
module tb_xoodyak_aead;

  logic         eph1;
  logic         reset;
  logic         start;
  logic [191:0] t_text;
  logic [127:0] t_nonce;
  logic [127:0] t_ad;
  logic [127:0] t_key;
  logic [127:0] t_vd;
  logic         t_op;
  logic         tamper;

  logic [127:0] authdata;
  logic [191:0] textout;
  logic         encdone;
  logic         sqzdone;
  logic         verify;

  logic [127:0] d_authdata;
  logic [191:0] d_textout;
  logic         d_encdone;
  logic         d_sqzdone;
  logic         d_verify;
  logic [127:0] d_vd;

  assign d_vd = authdata ^ {127'b0, tamper};

  xoodyak_aead u_enc (
    .eph1              (eph1),
    .reset             (reset),
    .start             (start),
    .textin            (t_text),
    .nonce             (t_nonce),
    .assodata          (t_ad),
    .key               (t_key),
    .verification_data (t_vd),
    .opmode            (t_op),
    .authdata          (authdata),
    .textout           (textout),
    .encdone           (encdone),
    .sqzdone           (sqzdone),
    .verify            (verify)
  );

  // Second instance chained off the first one's sqzdone.
  xoodyak_aead u_dec (
    .eph1              (eph1),
    .reset             (reset),
    .start             (sqzdone),
    .textin            (textout),
    .nonce             (t_nonce),
    .assodata          (t_ad),
    .key               (t_key),
    .verification_data (d_vd),
    .opmode            (1'b1),
    .authdata          (d_authdata),
    .textout           (d_textout),
    .encdone           (d_encdone),
    .sqzdone           (d_sqzdone),
    .verify            (d_verify)
  );

  initial eph1 = 1'b0;
  always #5 eph1 = ~eph1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge eph1);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ms [48];
  logic [31:0] cst [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                            32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

  function automatic logic [31:0] rot(input logic [31:0] w, input int v);
    if (v == 0) return w;
    return (w << v) | (w >> (32 - v));
  endfunction

  // Plane shift P<<<(t,v): lane x moves to x+t and rotates left by v.
  function automatic logic [127:0] pshift(input logic [127:0] pl, input int t, input int v);
    logic [127:0] r;
    for (int x = 0; x < 4; x++) r[32*((x+t)%4) +: 32] = rot(pl[32*x +: 32], v);
    return r;
  endfunction

  task automatic m_permute();
    logic [127:0] a0, a1, a2, p, e, b0, b1, b2;
    logic [383:0] flat;
    for (int i = 0; i < 48; i++) flat[8*i +: 8] = ms[i];
    a0 = flat[127:0];
    a1 = flat[255:128];
    a2 = flat[383:256];
    for (int r = 0; r < 12; r++) begin
      p  = a0 ^ a1 ^ a2;
      e  = pshift(p, 1, 5) ^ pshift(p, 1, 14);
      a0 = a0 ^ e;
      a1 = a1 ^ e;
      a2 = a2 ^ e;
      a1 = pshift(a1, 1, 0);
      a2 = pshift(a2, 0, 11);
      a0[31:0] = a0[31:0] ^ cst[r];
      b0 = a0 ^ (~a1 & a2);
      b1 = a1 ^ (~a2 & a0);
      b2 = a2 ^ (~a0 & a1);
      a0 = b0;
      a1 = pshift(b1, 0, 1);
      a2 = pshift(b2, 2, 8);
    end
    flat = {a2, a1, a0};
    for (int i = 0; i < 48; i++) ms[i] = flat[8*i +: 8];
  endtask

  // Down: absorb len bytes (left-aligned in v), pad 0x01, colour byte cd.
  task automatic m_down(input logic [191:0] v, input int len, input logic [7:0] cd);
    for (int i = 0; i < len; i++) ms[i] = ms[i] ^ v[191-8*i -: 8];
    ms[len] = ms[len] ^ 8'h01;
    ms[47]  = ms[47] ^ cd;
  endtask

  task automatic m_up(input logic [7:0] cu);
    ms[47] = ms[47] ^ cu;
    m_permute();
  endtask

  task automatic model(input logic [127:0] k, input logic [127:0] n, input logic [127:0] ad,
                       input logic [191:0] txt, input bit dec, input logic [127:0] vd,
                       output logic [191:0] otext, output logic [127:0] otag, output bit over);
    logic [191:0] ks, pt;
    for (int i = 0; i < 48; i++) ms[i] = 8'h00;
    m_down({k, 8'h00, 56'h0}, 17, 8'h02);
    m_up(8'h00);
    m_down({n, 64'h0}, 16, 8'h03);
    m_up(8'h00);
    m_down({ad, 64'h0}, 16, 8'h03);
    m_up(8'h80);
    for (int i = 0; i < 24; i++) ks[191-8*i -: 8] = ms[i];
    otext = txt ^ ks;
    pt    = dec ? otext : txt;
    m_down(pt, 24, 8'h00);
    m_up(8'h40);
    for (int i = 0; i < 16; i++) otag[127-8*i -: 8] = ms[i];
    over = dec && (otag == vd);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] nonce;
    logic [127:0] ad;
    logic [191:0] text;
    logic [127:0] vd;
    bit           dec;
    logic [191:0] exp_text;
    logic [127:0] exp_tag;
    bit           exp_verify;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic apply(input vec_t v);
    t_key   = v.key;
    t_nonce = v.nonce;
    t_ad    = v.ad;
    t_text  = v.text;
    t_vd    = v.vd;
    t_op    = v.dec;
  endtask

  task automatic run_op(input int nticks, input int pulse_at, output int enc_cyc,
                        output int sqz_cyc, output int enc_n, output int sqz_n);
    enc_cyc = 0;
    sqz_cyc = 0;
    enc_n   = 0;
    sqz_n   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= nticks; i++) begin
      start = (i == pulse_at);
      tick();
      if (encdone) begin enc_n++; enc_cyc = i + 1; end
      if (sqzdone) begin sqz_n++; sqz_cyc = i + 1; end
    end
    start = 1'b0;
  endtask

  localparam logic [191:0] PlainSpec = 192'h4142434445464748494a4b4c4d4e4f505152535455565758;

  initial begin
    int ec, sc, en, sn;
    logic [191:0] ct, tx;
    logic [127:0] tg;
    bit vf;
    bit found;

    reset  = 1'b1;
    start  = 1'b0;
    tamper = 1'b0;
    t_text = '0; t_nonce = '0; t_ad = '0; t_key = '0; t_vd = '0; t_op = 1'b0;

    // Table: spec vector, all-zero, random encrypts, random decrypts (good, tampered, junk).
    vecs[0] = '{128'h303132333435363738393a3b3c3d3e3f, 128'h4142434445464748494a4b4c4d4e4f50,
                128'h6162636465666768696a6b6c6d6e6f70, PlainSpec, 128'h0, 1'b0, '0, '0, 1'b0};
    vecs[1] = '{128'h0, 128'h0, 128'h0, 192'h0, 128'h0, 1'b0, '0, '0, 1'b0};
    for (int i = 2; i < 7; i++)
      vecs[i] = '{r128(), r128(), r128(), {r128(), $urandom, $urandom}, r128(), 1'b0,
                  '0, '0, 1'b0};
    for (int i = 4; i < 7; i++) vecs[i].dec = 1'b1;
    // Vectors 4 and 5 decrypt a genuine ciphertext; 5 carries a corrupted tag.
    for (int i = 4; i < 6; i++) begin
      model(vecs[i].key, vecs[i].nonce, vecs[i].ad, vecs[i].text, 1'b0, '0, ct, tg, vf);
      vecs[i].text = ct;
      vecs[i].vd   = (i == 4) ? tg : tg ^ (128'h1 << $urandom_range(127, 0));
    end
    for (int i = 0; i < 7; i++) begin
      model(vecs[i].key, vecs[i].nonce, vecs[i].ad, vecs[i].text, vecs[i].dec, vecs[i].vd,
            tx, tg, vf);
      vecs[i].exp_text   = tx;
      vecs[i].exp_tag    = tg;
      vecs[i].exp_verify = vf;
    end

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset authdata", {64'h0, authdata}, 192'h0);
    chk("reset textout", textout, 192'h0);
    chk("reset flags", {189'h0, encdone, sqzdone, verify}, 192'h0);

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i]);
      run_op(55, -1, ec, sc, en, sn);
      chk($sformatf("v%0d encdone cycle", i), 192'(ec), 192'd37);
      chk($sformatf("v%0d sqzdone cycle", i), 192'(sc), 192'd49);
      chk($sformatf("v%0d pulse counts", i), 192'({en[7:0], sn[7:0]}), 192'h0101);
      chk($sformatf("v%0d textout", i), textout, vecs[i].exp_text);
      chk($sformatf("v%0d authdata", i), {64'h0, authdata}, {64'h0, vecs[i].exp_tag});
      chk($sformatf("v%0d verify", i), {191'h0, verify}, {191'h0, vecs[i].exp_verify});
    end
    repeat (50) tick();

    // Chained round trip, then the same with a corrupted tag into the decryptor.
    for (int t = 0; t < 2; t++) begin
      tamper = (t == 1);
      apply(vecs[0]);
      run_op(55, -1, ec, sc, en, sn);
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
        tick();
        if (d_sqzdone) found = 1'b1;
      end
      chk($sformatf("rt%0d dec sqzdone seen", t), {191'h0, found}, 192'h1);
      chk($sformatf("rt%0d dec textout", t), d_textout, PlainSpec);
      chk($sformatf("rt%0d dec authdata", t), {64'h0, d_authdata}, {64'h0, vecs[0].exp_tag});
      chk($sformatf("rt%0d dec verify", t), {191'h0, d_verify}, {191'h0, t == 0});
      repeat (5) tick();
    end
    tamper = 1'b0;
    repeat (50) tick();

    // Start while busy is ignored.
    apply(vecs[2]);
    run_op(70, 10, ec, sc, en, sn);
    chk("busy sqzdone count", 192'(sn), 192'd1);
    chk("busy sqzdone cycle", 192'(sc), 192'd49);
    chk("busy textout", textout, vecs[2].exp_text);
    chk("busy authdata", {64'h0, authdata}, {64'h0, vecs[2].exp_tag});
    repeat (50) tick();

    // Reset mid-operation aborts silently; a fresh start then completes.
    apply(vecs[3]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset authdata", {64'h0, authdata}, 192'h0);
    chk("midreset textout", textout, 192'h0);
    chk("midreset flags", {189'h0, encdone, sqzdone, verify}, 192'h0);
    en = 0;
    sn = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (encdone) en++;
      if (sqzdone) sn++;
    end
    chk("midreset no pulses", 192'({en[7:0], sn[7:0]}), 192'h0);
    run_op(55, -1, ec, sc, en, sn);
    chk("post reset sqzdone cycle", 192'(sc), 192'd49);
    chk("post reset textout", textout, vecs[3].exp_text);
    chk("post reset authdata", {64'h0, authdata}, {64'h0, vecs[3].exp_tag});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xoodyak_aead.md
Name: xoodyak_aead

Overview:
- Single-block Xoodyak keyed-mode AEAD engine (Cyclist, Rkout = 24 bytes) built around a 384-bit Xoodoo[12] permutation that executes one round per clock.
- Inputs: 128-bit key, 128-bit nonce, one 128-bit associated-data block and one 192-bit text block. Output: 192-bit ciphertext or plaintext, plus a 128-bit tag.
- In decrypt mode it also compares the computed tag with a supplied tag.
- Encrypt and decrypt instances chain directly: the encryptor's sqzdone drives the decryptor's start.

Parameters:
- none

Ports:
- eph1  in  1  clock; all flops update on its rising edge (rregs-style q<=d registers).
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin operation; sampled only when idle.
- textin  in  192  plaintext (opmode=0) or ciphertext (opmode=1).
- nonce  in  128  nonce.
- assodata  in  128  associated data block.
- key  in  128  secret key.
- verification_data  in  128  expected tag; used only when opmode=1.
- opmode  in  1  0=encrypt, 1=decrypt; sampled with start.
- authdata  out  128  computed tag.
- textout  out  192  ciphertext (encrypt) or recovered plaintext (decrypt).
- encdone  out  1  one-cycle pulse: textout valid.
- sqzdone  out  1  one-cycle pulse: authdata and verify valid.
- verify  out  1  1 when opmode=1 and authdata==verification_data; 0 in encrypt mode.

Behaviour:
- Byte order:
  - Input/output vectors are byte strings, MSB byte first: bits [N-1:N-8] are byte 0.
  - State bytes 0..47 form 12 little-endian 32-bit lanes; lane index = 4*y + x (plane y 0..2, column x 0..3).
- Round (Xoodoo), applied in this order. Notation: A_y = plane y; P<<<(t,v) = move lane x to x+t mod 4 and rotate each lane left by v.
  - theta: P = A0^A1^A2; E = P<<<(1,5) ^ P<<<(1,14); every A_y ^= E.
  - rho-west: A1 <<<= (1,0); A2 <<<= (0,11).
  - iota: lane(0,0) ^= C_i.
  - chi: A_y ^= ~A_(y+1) & A_(y+2).
  - rho-east: A1 <<<= (0,1); A2 <<<= (2,8).
  - C_i for rounds 0..11: 058, 038, 3C0, 0D0, 120, 014, 060, 02C, 380, 0F0, 1A0, 012 (hex).
- FSM states:
  - IDLE: waits for start.
  - PERM: 2-bit permutation index k = 0..3 and 4-bit round counter 0..11.
  - Returns to IDLE after k=3, round 11.
- Edge E0 (start high in IDLE): load state = Down(key || 0x00, cd=0x02).
  - Bytes 0..15 = key, byte16 = 0x00, byte17 = 0x01, byte47 = 0x02, all others 0.
  - Latch opmode, textin, nonce, assodata, verification_data.
- Edges E1..E48: one round per edge. Permutation k covers edges 12k+1..12k+12.
- After the last round of each permutation, XOR the following into the round output on the same edge:
  - After k=0: nonce into bytes 0..15; 0x01 into byte16; 0x03 into byte47 (Down with cd=0x03, then Up with cu=0x00).
  - After k=1: assodata into bytes 0..15; 0x01 into byte16; 0x03^0x80 into byte47 (Down with cd=0x03, then Up with cu=0x80).
  - After k=2 (E36): keystream = bytes 0..23 of the round output.
    - textout <= textin ^ keystream.
    - P = textin when encrypting, textout value when decrypting.
    - XOR P into bytes 0..23; 0x01 into byte24; 0x40 into byte47 (cd=0x00, then cu=0x40).
  - After k=3 (E48):
    - authdata <= bytes 0..15.
    - verify <= opmode & (bytes 0..15 == verification_data).
- Timing:
  - encdone is high for exactly the cycle after E36.
  - sqzdone is high for exactly the cycle after E48.
  - Total latency from start to sqzdone = 49 cycles.
- Outputs hold until the next operation's corresponding update. textout/authdata/verify change only at E36/E48.
- start while in PERM is ignored. start during the sqzdone cycle is accepted, since the FSM is already IDLE.
- reset (synchronous) has priority over everything:
  - FSM goes to IDLE; counters and state are cleared.
  - authdata, textout, encdone, sqzdone and verify are all 0.
  - Reset mid-operation aborts with no done pulses.

Test Plan:
- Encrypt: key=303132333435363738393a3b3c3d3e3f, nonce=4142434445464748494a4b4c4d4e4f50, AD=6162636465666768696a6b6c6d6e6f70, text=4142434445464748494a4b4c4d4e4f505152535455565758, opmode=0.
  - encdone exactly 37 cycles after the start edge; sqzdone 12 cycles later.
  - textout/authdata match the Xoodyak software golden model; verify=0.
- Round trip: feed the encryptor's outputs into a second instance with opmode=1, started by the encryptor's sqzdone.
  - textout = 4142434445464748494a4b4c4d4e4f505152535455565758; authdata equals the encryptor tag; verify=1.
- Tamper: same decrypt with bit 0 of verification_data flipped -> verify=0; textout still equals the plaintext.
- Permutation check: all-zero key/nonce/AD/text; the tag and keystream must match the golden model. This exercises the round constants and rotations.
- Busy/reset:
  - start pulsed at cycle 10 of an operation -> ignored; only one sqzdone, at cycle 49.
  - reset at cycle 20 -> no encdone/sqzdone, all outputs 0; a new start then completes normally.
